ex_simple_pipe: RTL and testbench

Parametrised, registered successor to the simple-FU execute wrapper. Each cycle it picks the oldest operand-ready entry among NUM_RS reservation-station slots and runs it through the shared `alu`. Single-cycle ops finish in one cycle; multi-cycle ops (aluop[5]=1, e.g. divide) occupy the unit for MC_LAT cycles. Results are held in an output register under a valid/ready handshake toward the ROB/RF write port.

---
 rtl/ex_simple_pipe.sv | 233 +++++++++++++++++++++++
 tb/tb_ex_simple_pipe.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_simple_pipe.sv
// Registered execute stage: age-ordered pick from the reservation stations,
// shared alu, multi-cycle pacing and a valid/ready result register.

module alu (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [5:0]  aluop,
   output logic [31:0] result,
   output logic        divide_error
);

   logic unused_op;
   assign unused_op = ^aluop[4:3];

   // aluop[5]=1 selects divide (aluop[0]=0) or remainder (aluop[0]=1)
   always_comb begin
      result       = '0;
      divide_error = 1'b0;
      if (aluop[5]) begin
         if (b == '0) begin
            divide_error = 1'b1;
            result       = aluop[0] ? a : '1;
         end else begin
            result = aluop[0] ? (a % b) : (a / b);
         end
      end else begin
         unique case (aluop[2:0])
            3'd0: result = a + b;
            3'd1: result = a - b;
            3'd2: result = a & b;
            3'd3: result = a | b;
            3'd4: result = a ^ b;
            3'd5: result = a << b[4:0];
            3'd6: result = a >> b[4:0];
            3'd7: result = {31'b0, $signed(a) < $signed(b)};
         endcase
      end
   end

endmodule

module ex_simple_pipe #(
   parameter int NUM_RS = 2,
   parameter int RS_W   = 114,
   parameter int TAG_W  = 4,
   parameter int AGE_W  = 3,
   parameter int MC_LAT = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    flush,
   input  logic [NUM_RS*RS_W-1:0]  rs_entry,
   input  logic [NUM_RS*TAG_W-1:0] rs_tag,
   input  logic [NUM_RS*AGE_W-1:0] rs_age,
   output logic [NUM_RS-1:0]       issue,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [74:0]             executed_inst,
   output logic [TAG_W-1:0]        out_tag,
   output logic                    div_err,
   output logic [31:0]             writeData,
   output logic [4:0]              writeAddr,
   output logic                    writeEn
);

   localparam int CNT_W = (MC_LAT > 2) ? $clog2(MC_LAT - 1) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

   state_t state, state_nx;

   logic              any_rdy;
   logic [NUM_RS-1:0] win_oh;
   logic [AGE_W-1:0]  best_age;
   logic [31:0]       w_s1, w_s2;
   logic [5:0]        w_op;
   logic [4:0]        w_rd;
   logic              w_rw;
   logic [TAG_W-1:0]  w_tag;

   logic [31:0]       op_s1, op_s2;
   logic [5:0]        op_aluop;
   logic [4:0]        op_rd;
   logic              op_rw;
   logic [TAG_W-1:0]  op_tag;
   logic [CNT_W-1:0]  cnt;

   logic [31:0]       res_q;
   logic [4:0]        rd_q;
   logic              rw_q;
   logic [TAG_W-1:0]  tag_q;
   logic              derr_q;

   logic              busy, can_accept, do_issue;
   logic              load_mc, capture, cnt_zero;
   logic [31:0]       a_s1, a_s2, alu_res;
   logic [5:0]        a_op;
   logic [4:0]        a_rd;
   logic              a_rw, alu_err;
   logic [TAG_W-1:0]  a_tag;

   logic unused_rs;
   assign unused_rs = ^rs_entry;

   // Strict less-than keeps the lowest index on an age tie
   always_comb begin
      any_rdy  = 1'b0;
      win_oh   = '0;
      best_age = '0;
      w_s1     = '0;
      w_s2     = '0;
      w_op     = '0;
      w_rd     = '0;
      w_rw     = 1'b0;
      w_tag    = '0;
      for (int i = 0; i < NUM_RS; i++) begin
         if (rs_entry[i*RS_W+38] && rs_entry[i*RS_W+5] &&
             (!any_rdy || rs_age[i*AGE_W +: AGE_W] < best_age)) begin
            any_rdy   = 1'b1;
            win_oh    = '0;
            win_oh[i] = 1'b1;
            best_age  = rs_age[i*AGE_W +: AGE_W];
            w_s1      = rs_entry[i*RS_W+6  +: 32];
            w_s2      = rs_entry[i*RS_W+39 +: 32];
            w_op      = rs_entry[i*RS_W+76 +: 6];
            w_rd      = rs_entry[i*RS_W +: 5];
            w_rw      = rs_entry[i*RS_W+71];
            w_tag     = rs_tag[i*TAG_W +: TAG_W];
         end
      end
   end

   assign busy       = (state == BUSY);
   assign cnt_zero   = (cnt == '0);
   assign can_accept = (state == IDLE) | ((state == HOLD) & out_ready);
   assign do_issue   = can_accept & ~flush & any_rdy & rst_n;
   assign load_mc    = do_issue & w_op[5];
   assign capture    = (do_issue & ~w_op[5]) | (busy & cnt_zero & ~flush);

   assign a_s1  = busy ? op_s1    : w_s1;
   assign a_s2  = busy ? op_s2    : w_s2;
   assign a_op  = busy ? op_aluop : w_op;
   assign a_rd  = busy ? op_rd    : w_rd;
   assign a_rw  = busy ? op_rw    : w_rw;
   assign a_tag = busy ? op_tag   : w_tag;

   alu u_alu (
      .a            (a_s1),
      .b            (a_s2),
      .aluop        (a_op),
      .result       (alu_res),
      .divide_error (alu_err)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (flush) begin
         state_nx = IDLE;
      end else begin
         unique case (state)
            IDLE, HOLD: begin
               if (do_issue)
                  state_nx = w_op[5] ? BUSY : HOLD;
               else if (state == HOLD && !out_ready)
                  state_nx = HOLD;
               else
                  state_nx = IDLE;
            end
            BUSY: begin
               if (cnt_zero) state_nx = HOLD;
            end
            default: state_nx = IDLE;
         endcase
      end
   end

   always_comb begin
      out_valid = (state == HOLD);
      issue     = do_issue ? win_oh : '0;
      writeEn   = out_valid & out_ready & rw_q & ~flush;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt      <= '0;
         op_s1    <= '0;
         op_s2    <= '0;
         op_aluop <= '0;
         op_rd    <= '0;
         op_rw    <= 1'b0;
         op_tag   <= '0;
         res_q    <= '0;
         rd_q     <= '0;
         rw_q     <= 1'b0;
         tag_q    <= '0;
         derr_q   <= 1'b0;
      end else begin
         if (flush)
            cnt <= '0;
         else if (load_mc)
            cnt <= CNT_W'(MC_LAT - 2);
         else if (busy && !cnt_zero)
            cnt <= cnt - 1'b1;
         if (load_mc) begin
            op_s1    <= w_s1;
            op_s2    <= w_s2;
            op_aluop <= w_op;
            op_rd    <= w_rd;
            op_rw    <= w_rw;
            op_tag   <= w_tag;
         end
         if (capture) begin
            res_q  <= alu_res;
            derr_q <= alu_err;
            rd_q   <= a_rd;
            rw_q   <= a_rw;
            tag_q  <= a_tag;
         end
      end
   end

   assign executed_inst = {37'b0, rw_q, res_q, rd_q};
   assign writeData     = res_q;
   assign writeAddr     = rd_q;
   assign out_tag       = tag_q;
   assign div_err       = derr_q;

endmodule

// File: tb/tb_ex_simple_pipe.sv
// Directed and random checks of ex_simple_pipe against a
// cycle-level transaction model of the execute unit.

module tb_ex_simple_pipe;

   localparam int NUM_RS = 2;
   localparam int RS_W   = 114;
   localparam int TAG_W  = 4;
   localparam int AGE_W  = 3;
   localparam int MC_LAT = 8;

   logic                    clk = 1'b0;
   logic                    rst_n, flush, out_ready;
   logic [NUM_RS*RS_W-1:0]  rs_entry;
   logic [NUM_RS*TAG_W-1:0] rs_tag;
   logic [NUM_RS*AGE_W-1:0] rs_age;
   logic [NUM_RS-1:0]       issue;
   logic                    out_valid, div_err, writeEn;
   logic [74:0]             executed_inst;
   logic [TAG_W-1:0]        out_tag;
   logic [31:0]             writeData;
   logic [4:0]              writeAddr;

   always #5 clk = ~clk;

   ex_simple_pipe #(
      .NUM_RS(NUM_RS), .RS_W(RS_W), .TAG_W(TAG_W),
      .AGE_W(AGE_W), .MC_LAT(MC_LAT)
   ) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .rs_entry(rs_entry), .rs_tag(rs_tag), .rs_age(rs_age),
      .issue(issue), .out_valid(out_valid), .out_ready(out_ready),
      .executed_inst(executed_inst), .out_tag(out_tag),
      .div_err(div_err), .writeData(writeData),
      .writeAddr(writeAddr), .writeEn(writeEn)
   );

   int n_cmp = 0;
   int n_fail = 0;

   logic [31:0]      e_s1[NUM_RS], e_s2[NUM_RS];
   logic             e_v1[NUM_RS], e_v2[NUM_RS], e_rw[NUM_RS];
   logic [5:0]       e_op[NUM_RS];
   logic [4:0]       e_rd[NUM_RS];
   logic [AGE_W-1:0] e_age[NUM_RS];
   logic [TAG_W-1:0] e_tag[NUM_RS];
   logic [35:0]      e_junk[NUM_RS];

   logic             m_valid;
   int               m_busy;
   logic [31:0]      m_res, p_res;
   logic             m_err, p_err, m_rw, p_rw;
   logic [4:0]       m_rd, p_rd;
   logic [TAG_W-1:0] m_tag, p_tag;

   logic [NUM_RS-1:0] obs_issue;
   logic              obs_valid, obs_we, obs_err;
   logic [31:0]       obs_wd;
   logic [TAG_W-1:0]  obs_tag;

   task automatic check(string tag, logic [74:0] obs, logic [74:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [32:0] ref_alu(logic [5:0] op, logic [31:0] a, logic [31:0] b);
      if (op[5]) begin
         if (b == 0) return {1'b1, op[0] ? a : 32'hFFFF_FFFF};
         return {1'b0, op[0] ? a % b : a / b};
      end
      case (op[2:0])
         3'd0: return {1'b0, a + b};
         3'd1: return {1'b0, a - b};
         3'd2: return {1'b0, a & b};
         3'd3: return {1'b0, a | b};
         3'd4: return {1'b0, a ^ b};
         3'd5: return {1'b0, a << b[4:0]};
         3'd6: return {1'b0, a >> b[4:0]};
         default: return {1'b0, 31'b0, ($signed(a) < $signed(b))};
      endcase
   endfunction

   task automatic set_slot(int i, logic v, logic [5:0] op, logic [31:0] a,
                           logic [31:0] b, logic [AGE_W-1:0] age,
                           logic [TAG_W-1:0] tag, logic [4:0] rd, logic rw);
      e_v1[i] = v;  e_v2[i] = v;  e_op[i] = op;
      e_s1[i] = a;  e_s2[i] = b;  e_age[i] = age;
      e_tag[i] = tag; e_rd[i] = rd; e_rw[i] = rw;
      e_junk[i] = '0;
   endtask

   task automatic drive();
      logic [RS_W-1:0] e;
      for (int i = 0; i < NUM_RS; i++) begin
         e = '0;
         e[113:82] = e_junk[i][31:0];
         e[75:72]  = e_junk[i][35:32];
         e[81:76]  = e_op[i];
         e[71]     = e_rw[i];
         e[70:39]  = e_s2[i];
         e[38]     = e_v2[i];
         e[37:6]   = e_s1[i];
         e[5]      = e_v1[i];
         e[4:0]    = e_rd[i];
         rs_entry[i*RS_W +: RS_W]   = e;
         rs_tag[i*TAG_W +: TAG_W]   = e_tag[i];
         rs_age[i*AGE_W +: AGE_W]   = e_age[i];
      end
   endtask

   task automatic model_reset();
      m_valid = 1'b0;
      m_busy  = 0;
   endtask

   // One clock cycle: drive, predict, compare at mid-cycle, then advance the model
   task automatic cyc();
      int w, mn;
      logic can, fl, rdy;
      logic [NUM_RS-1:0] ei;
      logic ew;
      logic [32:0] r;
      drive();
      #4;
      mn = 1 << AGE_W;
      for (int i = 0; i < NUM_RS; i++)
         if (e_v1[i] && e_v2[i] && int'(e_age[i]) < mn) mn = int'(e_age[i]);
      w = -1;
      for (int i = NUM_RS - 1; i >= 0; i--)
         if (e_v1[i] && e_v2[i] && int'(e_age[i]) == mn) w = i;
      can = (m_busy == 0) && (!m_valid || out_ready);
      ei  = '0;
      if (can && !flush && w >= 0) ei[w] = 1'b1;
      ew  = m_valid && out_ready && m_rw && !flush;
      check("issue", 75'(issue), 75'(ei));
      check("out_valid", 75'(out_valid), 75'(m_valid));
      check("writeEn", 75'(writeEn), 75'(ew));
      if (m_valid) begin
         check("writeData", 75'(writeData), 75'(m_res));
         check("out_tag", 75'(out_tag), 75'(m_tag));
         check("writeAddr", 75'(writeAddr), 75'(m_rd));
         check("div_err", 75'(div_err), 75'(m_err));
         check("executed_inst", executed_inst, {37'b0, m_rw, m_res, m_rd});
      end
      obs_issue = issue;  obs_valid = out_valid; obs_we = writeEn;
      obs_wd = writeData; obs_tag = out_tag;     obs_err = div_err;
      fl  = flush;
      rdy = out_ready;
      @(posedge clk);
      if (fl) begin
         model_reset();
      end else begin
         if (m_valid && rdy) m_valid = 1'b0;
         if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) begin
               m_valid = 1'b1;
               m_res = p_res; m_err = p_err; m_rd = p_rd;
               m_rw = p_rw;   m_tag = p_tag;
            end
         end
         if (ei != 0) begin
            r = ref_alu(e_op[w], e_s1[w], e_s2[w]);
            if (e_op[w][5]) begin
               m_busy = MC_LAT - 1;
               p_res = r[31:0]; p_err = r[32]; p_rd = e_rd[w];
               p_rw = e_rw[w];  p_tag = e_tag[w];
            end else begin
               m_valid = 1'b1;
               m_res = r[31:0]; m_err = r[32]; m_rd = e_rd[w];
               m_rw = e_rw[w];  m_tag = e_tag[w];
            end
         end
      end
      #1;
   endtask

   initial begin
      int unsigned x;
      rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < NUM_RS; i++) set_slot(i, 1'b1, 6'h0, 1, 2, 0, 1, 1, 1'b1);
      drive();
      model_reset();
      #2;
      check("rst_out_valid", 75'(out_valid), 75'(0));
      check("rst_issue", 75'(issue), 75'(0));
      check("rst_writeEn", 75'(writeEn), 75'(0));
      check("rst_exec", executed_inst, 75'(0));
      check("rst_tag", 75'(out_tag), 75'(0));
      check("rst_wd", 75'(writeData), 75'(0));
      check("rst_wa", 75'(writeAddr), 75'(0));
      check("rst_derr", 75'(div_err), 75'(0));
      @(posedge clk); #1;
      rst_n = 1'b1;
      set_slot(0, 1'b0, 6'h0, 0, 0, 0, 0, 0, 1'b0);
      set_slot(1, 1'b0, 6'h0, 0, 0, 0, 0, 0, 1'b0);
      cyc();

      // single ADD from slot 1
      set_slot(1, 1'b1, 6'h0, 5, 7, 2, 9, 3, 1'b1);
      cyc();
      check("add_issue", 75'(obs_issue), 75'(2'b10));
      e_v1[1] = 1'b0;
      cyc();
      check("add_valid", 75'(obs_valid), 75'(1));
      check("add_wd", 75'(obs_wd), 75'(12));
      check("add_tag", 75'(obs_tag), 75'(9));
      check("add_we", 75'(obs_we), 75'(1));

      // age selection, then tie
      set_slot(0, 1'b1, 6'h0, 1, 1, 3, 1, 1, 1'b1);
      set_slot(1, 1'b1, 6'h1, 9, 4, 1, 2, 2, 1'b1);
      cyc();
      check("age_issue", 75'(obs_issue), 75'(2'b10));
      e_age[0] = 4; e_age[1] = 4;
      cyc();
      check("tie_issue", 75'(obs_issue), 75'(2'b01));
      e_v1[0] = 1'b0; e_v1[1] = 1'b0;
      cyc();

      // multi-cycle divide with a waiting slot
      set_slot(0, 1'b1, 6'h20, 100, 7, 2, 6, 4, 1'b1);
      cyc();
      check("div_issue", 75'(obs_issue), 75'(2'b01));
      e_v1[0] = 1'b0;
      set_slot(1, 1'b1, 6'h0, 1, 1, 0, 5, 7, 1'b1);
      for (int k = 1; k < MC_LAT; k++) begin
         cyc();
         check("div_busy_issue", 75'(obs_issue), 75'(0));
      end
      cyc();
      check("div_valid", 75'(obs_valid), 75'(1));
      check("div_wd", 75'(obs_wd), 75'(14));
      check("div_next_issue", 75'(obs_issue), 75'(2'b10));
      check("div_we", 75'(obs_we), 75'(1));

      // backpressure
      e_v1[1] = 1'b0;
      set_slot(0, 1'b1, 6'h0, 10, 20, 1, 8, 9, 1'b1);
      out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         cyc();
         check("bp_wd", 75'(obs_wd), 75'(2));
         check("bp_tag", 75'(obs_tag), 75'(5));
         check("bp_issue", 75'(obs_issue), 75'(0));
         check("bp_we", 75'(obs_we), 75'(0));
      end
      out_ready = 1'b1;
      cyc();
      check("bp_rel_we", 75'(obs_we), 75'(1));
      check("bp_rel_issue", 75'(obs_issue), 75'(2'b01));
      e_v1[0] = 1'b0;
      cyc();

      // flush while busy
      set_slot(0, 1'b1, 6'h20, 50, 5, 0, 3, 6, 1'b1);
      cyc();
      e_v1[0] = 1'b0;
      cyc();
      cyc();
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      for (int k = 0; k < 7; k++) begin
         cyc();
         check("flush_no_valid", 75'(obs_valid), 75'(0));
      end

      // divide by zero
      set_slot(0, 1'b1, 6'h20, 77, 0, 0, 4, 2, 1'b1);
      cyc();
      e_v1[0] = 1'b0;
      for (int k = 1; k < MC_LAT; k++) cyc();
      out_ready = 1'b0;
      cyc();
      check("dz_valid", 75'(obs_valid), 75'(1));
      check("dz_err", 75'(obs_err), 75'(1));
      check("dz_wd", 75'(obs_wd), 75'(32'hFFFF_FFFF));

      // async reset while holding a result
      set_slot(0, 1'b1, 6'h0, 3, 4, 0, 1, 1, 1'b1);
      drive();
      out_ready = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_valid", 75'(out_valid), 75'(0));
      check("arst_we", 75'(writeEn), 75'(0));
      check("arst_issue", 75'(issue), 75'(0));
      check("arst_wd", 75'(writeData), 75'(0));
      model_reset();
      @(posedge clk); #1;
      rst_n = 1'b1;

      // randomized traffic
      for (int c = 0; c < 1500; c++) begin
         for (int i = 0; i < NUM_RS; i++) begin
            x = $urandom_range(0, 9);
            e_op[i]  = (x < 8) ? 6'(x) : ((x == 8) ? 6'h20 : 6'h21);
            e_v1[i]  = ($urandom_range(0, 9) < 6);
            e_v2[i]  = ($urandom_range(0, 9) < 7);
            e_s1[i]  = $urandom;
            e_s2[i]  = ($urandom_range(0, 3) == 0) ? 32'(0) : $urandom;
            e_age[i] = AGE_W'($urandom);
            e_tag[i] = TAG_W'($urandom);
            e_rd[i]  = 5'($urandom);
            e_rw[i]  = ($urandom_range(0, 3) != 0);
            e_junk[i] = {4'($urandom), $urandom};
         end
         out_ready = ($urandom_range(0, 9) < 7);
         flush     = ($urandom_range(0, 19) == 0);
         cyc();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
